// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: one request at a time, LATENCY wait states, single-cycle response.
// Optional per-lane store enables under `DMEM_BYTE_EN_EN.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        REQ_valid,
  output logic        REQ_ready,
  input  logic        REQ_write,
  input  logic [31:0] REQ_address,
  input  logic [31:0] REQ_wdata,
  input  logic [3:0]  REQ_byte_en,
  output logic        RSP_valid,
  output logic [31:0] RSP_rdata,
  output logic        RSP_error,
  output logic        MEM_stall
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    cap_write;
  logic [31:0]             cap_address;
  logic [31:0]             cap_wdata;
  logic                    acc_write;
  logic [31:0]             acc_address;
  logic [31:0]             acc_wdata;
  logic [31:0]             offset;
  logic                    acc_error;
  logic [ADDR_WIDTH-1:0]   acc_index;
  logic                    enter_resp;
  logic                    mem_we;
  logic [31:0]             mem [0:DEPTH-1];

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (REQ_valid) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) cnt_next = cnt - 4'd1;
        else             state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      cap_write   <= 1'b0;
      cap_address <= 32'd0;
      cap_wdata   <= 32'd0;
    end else if (state == IDLE && REQ_valid) begin
      cap_write   <= REQ_write;
      cap_address <= REQ_address;
      cap_wdata   <= REQ_wdata;
    end
  end

`ifdef DMEM_BYTE_EN_EN
  logic [3:0] cap_byte_en;
  logic [3:0] acc_byte_en;

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset)                      cap_byte_en <= 4'd0;
    else if (state == IDLE && REQ_valid) cap_byte_en <= REQ_byte_en;
  end

  assign acc_byte_en = (state == IDLE) ? REQ_byte_en : cap_byte_en;
`else
  logic unused_byte_en;
  assign unused_byte_en = ^REQ_byte_en;
`endif

  // With LATENCY==0 the array is accessed on the accept edge, so live request fields are used.
  always_comb begin
    acc_write   = cap_write;
    acc_address = cap_address;
    acc_wdata   = cap_wdata;
    if (state == IDLE) begin
      acc_write   = REQ_write;
      acc_address = REQ_address;
      acc_wdata   = REQ_wdata;
    end
  end

  assign offset    = acc_address - BASE_ADDR;
  assign acc_error = (acc_address[1:0] != 2'b00) ||
                     (acc_address < BASE_ADDR) ||
                     ((offset >> (ADDR_WIDTH + 2)) != 32'd0);
  assign acc_index = offset[ADDR_WIDTH+1:2];

  logic unused_offset;
  assign unused_offset = ^offset[1:0];

  assign enter_resp = (state_next == RESP) && (state != RESP);
  assign mem_we     = enter_resp && acc_write && !acc_error && !SYS_reset;

  always_ff @(negedge SYS_clk) begin
    if (mem_we) begin
`ifdef DMEM_BYTE_EN_EN
      for (int i = 0; i < 4; i++) begin
        if (acc_byte_en[i]) mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
`else
      mem[acc_index] <= acc_wdata;
`endif
    end
  end

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      RSP_rdata <= 32'd0;
      RSP_error <= 1'b0;
    end else if (enter_resp) begin
      RSP_rdata <= (acc_write || acc_error) ? 32'd0 : mem[acc_index];
      RSP_error <= acc_error;
    end else if (state == RESP) begin
      RSP_rdata <= 32'd0;
      RSP_error <= 1'b0;
    end
  end

  assign RSP_valid = (state == RESP);
  assign REQ_ready = (state == IDLE) && !SYS_reset;
  assign MEM_stall = REQ_valid && !RSP_valid;

endmodule
